// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths and the program-loader state encoding.
package cpu_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int PC_WIDTH = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;
endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: shifts little-endian stream bytes into a word and flags the last byte of each word.
module word_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             word_full
);
    localparam int BPW = WIDTH / 8;
    localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
    logic [CW-1:0] cnt;
    assign word_full = shift && cnt == CW'(BPW - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
        end else begin
            if (clr) cnt <= '0;
            else if (shift) cnt <= word_full ? '0 : cnt + CW'(1);
            // newest byte enters at the top so byte 0 ends up in bits [7:0]
            if (shift) word <= (word >> 8) | (WIDTH'(byte_in) << (WIDTH - 8));
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed, XOR-checksummed byte image into instruction memory
// while holding the core in halt.
module prog_loader #(
    parameter int INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
    parameter int PC_WIDTH = cpu_pkg::PC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic                         mem_we,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         cpu_halt,
    output logic                         done,
    output logic                         error,
    output logic [PC_WIDTH:0]            words_loaded
);
    import cpu_pkg::*;
    localparam int WL_W = PC_WIDTH + 1;
    loader_state_t state, state_next;
    logic [7:0] csum, len_lo;
    logic [WL_W-1:0] len;
    logic word_full, hs, start_ok, len_bad;
    assign hs = rx_valid && rx_ready;
    assign start_ok = start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign len_bad = {rx_data, len_lo} == 16'd0 || int'({rx_data, len_lo}) > (1 << PC_WIDTH);
    word_assembler #(.WIDTH(INSTRUCTION_WIDTH)) u_asm (
        .clk(clk),
        .rst(rst),
        .clr(start_ok),
        .shift(hs && state == S_DATA),
        .byte_in(rx_data),
        .word(mem_wdata),
        .word_full(word_full)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_next;
    end
    always_comb begin
        rx_ready = state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM};
        mem_we = state == S_WRITE;
        cpu_halt = !(state inside {S_IDLE, S_DONE, S_ERROR});
        done = state == S_DONE;
        error = state == S_ERROR;
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: state_next = start ? S_HDR_LO : state;
            S_HDR_LO: state_next = hs ? S_HDR_HI : state;
            S_HDR_HI: state_next = hs ? (len_bad ? S_ERROR : S_DATA) : state;
            S_DATA: state_next = word_full ? S_WRITE : state;
            S_WRITE: state_next = words_loaded + WL_W'(1) == len ? S_CSUM : S_DATA;
            S_CSUM: state_next = hs ? (rx_data == csum ? S_DONE : S_ERROR) : state;
            default: state_next = S_IDLE;
        endcase
    end
    // length fits in WL_W bits whenever it passes the range check, so truncation is safe
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr     <= '0;
            words_loaded <= '0;
            csum         <= '0;
            len_lo       <= '0;
            len          <= '0;
        end else begin
            if (start_ok) begin
                mem_addr     <= '0;
                words_loaded <= '0;
                csum         <= '0;
            end
            if (hs && state != S_CSUM) csum <= csum ^ rx_data;
            if (hs && state == S_HDR_LO) len_lo <= rx_data;
            if (hs && state == S_HDR_HI) len <= WL_W'({rx_data, len_lo});
            if (state == S_WRITE) begin
                mem_addr     <= mem_addr + PC_WIDTH'(1);
                words_loaded <= words_loaded + WL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed load scenarios with a write scoreboard checked on every mem_we.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst, start, rx_valid, rx_ready, mem_we, cpu_halt, done, error;
    logic [7:0]  rx_data, mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words_loaded;
    int          checks = 0;
    int          passed = 0;
    logic [39:0] sb[$];
    logic [31:0] img[256];
    logic [39:0] e;

    prog_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_halt(cpu_halt),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("mem_addr", mem_addr, e[39:32]);
                chk("mem_wdata", mem_wdata, e[31:0]);
                chk("rx_ready_in_write", rx_ready, 0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rx_ready_timeout", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_cpu_halt"}, cpu_halt, 0);
        chk({tag, "_flags"}, {done, error}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic run_load(input int n, input logic [15:0] len, input bit bad_csum,
                            input bit send_csum, input bit gaps, input int mid_start);
        logic [7:0] x, b;
        x = len[7:0] ^ len[15:8];
        pulse_start();
        chk("halt_after_start", cpu_halt, 1);
        chk("wl_cleared", words_loaded, 0);
        chk("flags_cleared", {done, error}, 0);
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        for (int i = 0; i < n; i++) begin
            if (i == mid_start) begin
                @(negedge clk);
                pulse_start();
                chk("halt_mid_start", cpu_halt, 1);
                chk("wl_mid_start", words_loaded, i);
            end
            sb.push_back({8'(i), img[i]});
            for (int k = 0; k < 4; k++) begin
                b = img[i][8*k +: 8];
                x ^= b;
                send_byte(b, gaps);
            end
            chk("we_latency", mem_we, 1);
        end
        if (send_csum) send_byte(bad_csum ? ~x : x, gaps);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        img[0] = 32'h44332211;
        img[1] = 32'h88776655;
        run_load(2, 16'h0002, 0, 1, 0, -1);
        chk("t1_done", {done, error}, 2'b10);
        chk("t1_words", words_loaded, 2);
        chk("t1_addr", mem_addr, 2);
        chk("t1_halt", cpu_halt, 0);
        chk("t1_sb_drained", sb.size(), 0);

        run_load(2, 16'h0002, 1, 1, 0, -1);
        chk("t2_flags", {done, error}, 2'b01);
        chk("t2_halt", cpu_halt, 0);
        chk("t2_words", words_loaded, 2);
        chk("t2_sb_drained", sb.size(), 0);

        run_load(0, 16'h0000, 0, 0, 0, -1);
        chk("t3_len0_flags", {done, error}, 2'b01);
        chk("t3_len0_halt", cpu_halt, 0);
        repeat (3) @(negedge clk);
        chk("t3_len0_rx_ready", rx_ready, 0);
        run_load(0, 16'h0101, 0, 0, 0, -1);
        chk("t3_len257_flags", {done, error}, 2'b01);
        chk("t3_len257_words", words_loaded, 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 256; i++) img[i] = $urandom;
        run_load(256, 16'h0100, 0, 1, 1, -1);
        chk("t4_done", {done, error}, 2'b10);
        chk("t4_words", words_loaded, 256);
        chk("t4_addr", mem_addr, 0);
        chk("t4_sb_drained", sb.size(), 0);

        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        sb.push_back({8'd0, img[0]});
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
        send_byte(img[1][7:0], 0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("t5_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("t5_after");
        chk("t5_sb_drained", sb.size(), 0);

        run_load(3, 16'h0003, 0, 1, 0, 1);
        chk("t6_done", {done, error}, 2'b10);
        chk("t6_words", words_loaded, 3);
        chk("t6_addr", mem_addr, 3);
        chk("t6_sb_drained", sb.size(), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
